// File: rtl/disparity_ad_wta.sv
// Absolute-difference stereo matching cost over DISPARITY_RANGE candidates with a
// fully registered winner-takes-all argmin tree; sync signals are delay-matched.
module disparity_ad_wta #(
  parameter int unsigned DISPARITY_RANGE = 16,
  parameter int unsigned PIXEL_BITS      = 8,
  parameter int unsigned DISP_SHIFT      = 4,
  parameter int unsigned INVALID_COST    = (2 ** PIXEL_BITS) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  de_in,
  input  logic                  h_sync_in,
  input  logic                  v_sync_in,
  input  logic [PIXEL_BITS-1:0] pixel_left,
  input  logic [PIXEL_BITS-1:0] pixel_right,
  output logic                  de_out,
  output logic                  h_sync_out,
  output logic                  v_sync_out,
  output logic [7:0]            pixel_disparity,
  output logic [PIXEL_BITS-1:0] min_cost
);

  localparam int unsigned D     = DISPARITY_RANGE;
  localparam int unsigned PB    = PIXEL_BITS;
  localparam int unsigned IW    = $clog2(D);
  localparam int unsigned LAT   = 1 + IW;
  localparam int unsigned SW    = IW + DISP_SHIFT;
  localparam int unsigned NODES = 2 * D;

  // Tree nodes use heap numbering: root 1 (output register), children 2n/2n+1, leaf d at D+d.
  logic [PB-1:0] line_q [D-1];
  logic [PB-1:0] line_d [D-1];
  logic [IW-1:0] col_q, col_d;
  logic [PB-1:0] cand [D];
  logic [PB-1:0] cost_q [2:NODES-1];
  logic [PB-1:0] cost_d [2:NODES-1];
  logic [IW-1:0] idx_q  [2:NODES-1];
  logic [IW-1:0] idx_d  [2:NODES-1];
  logic [2:0]    sync_q [LAT];
  logic [2:0]    sync_d [LAT];
  logic [7:0]    disp_q, disp_d;
  logic [PB-1:0] mcost_q, mcost_d;
  logic [IW-1:0] win_idx;
  logic [PB-1:0] win_cost;
  logic [SW-1:0] win_shift;

  always_comb begin
    line_d    = line_q;
    col_d     = '0;
    cost_d    = cost_q;
    idx_d     = idx_q;
    disp_d    = '0;
    mcost_d   = '0;
    win_idx   = '0;
    win_cost  = '0;
    win_shift = '0;

    // Right delay line and column counter only advance on active pixels.
    if (de_in) begin
      line_d[0] = pixel_right;
      for (int unsigned k = 1; k < D - 1; k++) line_d[k] = line_q[k-1];
      col_d = (col_q == IW'(D - 1)) ? col_q : col_q + IW'(1);
    end

    cand[0] = pixel_right;
    for (int unsigned d = 1; d < D; d++) cand[d] = line_q[d-1];

    // Leaves: AD cost, candidates past the current column are off-image.
    for (int unsigned d = 0; d < D; d++) begin
      idx_d[D+d] = IW'(d);
      if (IW'(d) > col_q)
        cost_d[D+d] = PB'(INVALID_COST);
      else if (pixel_left >= cand[d])
        cost_d[D+d] = pixel_left - cand[d];
      else
        cost_d[D+d] = cand[d] - pixel_left;
    end

    // Internal nodes: the left child holds lower indices, so it wins ties.
    for (int unsigned n = 2; n < D; n++) begin
      if (cost_q[2*n+1] < cost_q[2*n]) begin
        cost_d[n] = cost_q[2*n+1];
        idx_d[n]  = idx_q[2*n+1];
      end else begin
        cost_d[n] = cost_q[2*n];
        idx_d[n]  = idx_q[2*n];
      end
    end

    if (cost_q[3] < cost_q[2]) begin
      win_cost = cost_q[3];
      win_idx  = idx_q[3];
    end else begin
      win_cost = cost_q[2];
      win_idx  = idx_q[2];
    end
    win_shift = SW'(win_idx) << DISP_SHIFT;

    // Root stage is masked with the de that travels alongside it.
    if (sync_q[LAT-2][2]) begin
      disp_d  = 8'(win_shift);
      mcost_d = win_cost;
    end

    sync_d[0] = {de_in, h_sync_in, v_sync_in};
    for (int unsigned k = 1; k < LAT; k++) sync_d[k] = sync_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q  <= '{default: '0};
      col_q   <= '0;
      cost_q  <= '{default: '0};
      idx_q   <= '{default: '0};
      sync_q  <= '{default: '0};
      disp_q  <= '0;
      mcost_q <= '0;
    end else begin
      line_q  <= line_d;
      col_q   <= col_d;
      cost_q  <= cost_d;
      idx_q   <= idx_d;
      sync_q  <= sync_d;
      disp_q  <= disp_d;
      mcost_q <= mcost_d;
    end
  end

  assign de_out          = sync_q[LAT-1][2];
  assign h_sync_out      = sync_q[LAT-1][1];
  assign v_sync_out      = sync_q[LAT-1][0];
  assign pixel_disparity = disp_q;
  assign min_cost        = mcost_q;

endmodule

// File: tb/tb_disparity_ad_wta.sv
// Bench for disparity_ad_wta: directed stereo lines plus random traffic against a
// behavioural matching-cost model, compared every cycle.
module tb_disparity_ad_wta;
  localparam int D   = 16;
  localparam int LAT = 5;
  localparam int INV = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
  logic [7:0] pixel_left = '0, pixel_right = '0;
  logic       de_out, h_sync_out, v_sync_out;
  logic [7:0] pixel_disparity, min_cost;

  disparity_ad_wta #(.DISPARITY_RANGE(16), .PIXEL_BITS(8), .DISP_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .pixel_left(pixel_left), .pixel_right(pixel_right), .de_out(de_out),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .pixel_disparity(pixel_disparity), .min_cost(min_cost)
  );

  always #5 clk = ~clk;

  typedef struct { bit de; bit h; bit v; int disp; int cost; } exp_t;

  exp_t mq[$];
  int   hist[D-1];
  int   line_cnt = 0;
  int   cyc_n = 0;
  int   t_in = -1, t_out = -1;
  int   vectors = 0, miscompares = 0;
  bit   done = 1'b0;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Lowest disparity with the smallest cost; candidates beyond col are invalid.
  function automatic void wta(input int l, input int c[D], input int col,
                              output int idx, output int cost);
    int cc;
    idx  = 0;
    cost = absdiff(l, c[0]);
    for (int d = 1; d < D; d++) begin
      cc = (d > col) ? INV : absdiff(l, c[d]);
      if (cc < cost) begin
        cost = cc;
        idx  = d;
      end
    end
  endfunction

  // Reference: expected outputs appear LAT clocks after the sampled input.
  always @(posedge clk) begin
    exp_t e;
    int   c[D];
    int   idx, cost;
    if (rst) begin
      mq.delete();
      e = '{de: 1'b0, h: 1'b0, v: 1'b0, disp: 0, cost: 0};
      for (int k = 0; k < LAT; k++) mq.push_front(e);
      for (int k = 0; k < D - 1; k++) hist[k] = 0;
      line_cnt = 0;
    end else begin
      e = '{de: de_in, h: h_sync_in, v: v_sync_in, disp: 0, cost: 0};
      if (de_in) begin
        if (t_in < 0) t_in = cyc_n;
        c[0] = int'(pixel_right);
        for (int d = 1; d < D; d++) c[d] = hist[d-1];
        wta(int'(pixel_left), c, (line_cnt > D - 1) ? D - 1 : line_cnt, idx, cost);
        e.disp = (idx * 16) % 256;
        e.cost = cost;
        for (int k = D - 2; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(pixel_right);
        line_cnt++;
      end else begin
        line_cnt = 0;
      end
      mq.push_front(e);
      if (mq.size() > LAT) void'(mq.pop_back());
    end
    cyc_n++;
  end

  task automatic cyc(input bit d, input bit hh, input bit vv, input int l, input int r);
    de_in = d; h_sync_in = hh; v_sync_in = vv;
    pixel_left = 8'(l); pixel_right = 8'(r);
    @(negedge clk);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, (i == 2) || (i == 3), i == 4, 0, 0);
  endtask

  task automatic pin(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Stimulus
  initial begin
    int r[16];
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    blank(2);
    // uniform shift of 3: right[x] = left[x+3]
    for (int x = 0; x < 32; x++) cyc(1'b1, 1'b0, 1'b0, (10 * x) % 256, (10 * (x + 3)) % 256);
    blank(7);
    for (int x = 0; x < 20; x++) cyc(1'b1, 1'b0, 1'b0, 100, 100);
    blank(7);
    // previous-line garbage 255 then an edge line with left 255, right 0
    for (int x = 0; x < 16; x++) cyc(1'b1, 1'b0, 1'b0, $urandom_range(0, 255), 255);
    blank(7);
    for (int x = 0; x < 16; x++) cyc(1'b1, 1'b0, 1'b0, 255, 0);
    blank(7);
    // tie at column 15 between d=2 and d=9
    for (int x = 0; x < 16; x++) r[x] = (x == 13) ? 105 : (x == 6) ? 95 : 130;
    for (int x = 0; x < 16; x++) cyc(1'b1, 1'b0, 1'b0, (x == 15) ? 100 : $urandom_range(0, 255), r[x]);
    blank(7);
    // random traffic with one mid-line reset carrying active pixels
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
        rst = 1'b0;
      end
      if ($urandom_range(0, 40) == 0) blank(7);
      if (i % 2 == 0)
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 255), $urandom_range(0, 255));
      else
        cyc($urandom_range(0, 9) != 0, 1'b0, 1'b0, $urandom_range(100, 103), $urandom_range(100, 103));
    end
    blank(LAT + 3);
    done = 1'b1;
  end

  // Checker: model pins, then per-cycle DUT comparison
  initial begin
    int c[D];
    int idx, cost, budget;
    exp_t x;
    for (int d = 0; d < D; d++) c[d] = (10 * (8 - d) + 256) % 256;
    wta(50, c, 5, idx, cost);
    pin("shift x5 disp", (idx * 16) % 256, 48);
    pin("shift x5 cost", cost, 0);
    for (int d = 0; d < D; d++) c[d] = (10 * (23 - d)) % 256;
    wta(200, c, 15, idx, cost);
    pin("shift x20 disp", (idx * 16) % 256, 48);
    for (int d = 0; d < D; d++) c[d] = 100;
    wta(100, c, 0, idx, cost);
    pin("edge col0 disp", idx, 0);
    wta(100, c, 9, idx, cost);
    pin("flat col9 disp", idx, 0);
    pin("flat col9 cost", cost, 0);
    for (int d = 0; d < D; d++) c[d] = (d == 0) ? 0 : 255;
    wta(255, c, 0, idx, cost);
    pin("invalid col0 disp", idx, 0);
    pin("invalid col0 cost", cost, 255);
    for (int d = 0; d < D; d++) c[d] = (d == 2) ? 105 : (d == 9) ? 95 : 130;
    wta(100, c, 15, idx, cost);
    pin("tie disp", (idx * 16) % 256, 32);
    pin("tie cost", cost, 5);

    budget = 0;
    while (!done && budget < 20000) begin
      @(negedge clk);
      budget++;
      if (mq.size() == LAT) begin
        x = mq[LAT-1];
        vectors++;
        if (de_out !== x.de || h_sync_out !== x.h || v_sync_out !== x.v ||
            int'(pixel_disparity) != x.disp || int'(min_cost) != x.cost) begin
          miscompares++;
          $display("FAIL cycle %0d outputs de/h/v/disp/cost: got %b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                   cyc_n, de_out, h_sync_out, v_sync_out, pixel_disparity, min_cost,
                   x.de, x.h, x.v, x.disp, x.cost);
        end
      end
      if (de_out === 1'b1 && t_out < 0 && t_in >= 0) t_out = cyc_n;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: got %0d cycles, expected stimulus completion", budget);
    end
    pin("first de_out latency", t_out - t_in, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
